// File: rtl/vga_pkg.sv
// Shared VGA line-buffer definitions: controller state encoding,
// one-hot buffer identifiers and default screen geometry.
package vga_pkg;

  localparam int DEF_WIDTH_PX   = 640;
  localparam int DEF_HEIGHT_PX  = 480;
  localparam int DEF_TILE_WIDTH = 4;

  localparam logic [1:0] BUFF_A = 2'b01;
  localparam logic [1:0] BUFF_B = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PRIME0,
    PRIME1,
    ACTIVE,
    FILL
  } line_ctrl_state_t;

  // The other buffer of the ping-pong pair (swap of a one-hot pair).
  function automatic logic [1:0] other_buff(input logic [1:0] buff);
    return {buff[0], buff[1]};
  endfunction

endpackage

// File: rtl/line_buff_ctrl_tile_ctr.sv
// tile_ctr: pixel sub-counter and displayed tile index. The index
// saturates at the last tile of the line, and both counters clear
// whenever the display is inactive.
module tile_ctr #(
  parameter int TILE_WIDTH     = 4,
  parameter int TILE_PER_LINE  = 160,
  parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pxl_ce,
  input  logic                      disp_active,
  output logic [TILE_CTR_WIDTH-1:0] tile_id
);

  localparam int SUB_WIDTH = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
  localparam logic [SUB_WIDTH-1:0]      SUB_LAST  = SUB_WIDTH'(TILE_WIDTH - 1);
  localparam logic [SUB_WIDTH-1:0]      SUB_ONE   = SUB_WIDTH'(1);
  localparam logic [TILE_CTR_WIDTH-1:0] TILE_LAST = TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
  localparam logic [TILE_CTR_WIDTH-1:0] TILE_ONE  = TILE_CTR_WIDTH'(1);

  logic [SUB_WIDTH-1:0] sub_ctr;

  // Count pixels within a tile and advance the tile index on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_ctr <= '0;
      tile_id <= '0;
    end else if (!disp_active) begin
      sub_ctr <= '0;
      tile_id <= '0;
    end else if (pxl_ce) begin
      if (sub_ctr == SUB_LAST) begin
        sub_ctr <= '0;
        if (tile_id != TILE_LAST) begin
          tile_id <= tile_id + TILE_ONE;
        end
      end else begin
        sub_ctr <= sub_ctr + SUB_ONE;
      end
    end
  end

endmodule

// File: rtl/line_buff_ctrl.sv
// line_buff_ctrl: ping-pong line-buffer controller. Primes both buffers
// at frame start, swaps the displayed buffer at every line end and
// requests a refill of the buffer that just finished displaying.
// Optional sticky underrun flag: define LINE_BUFF_CTRL_UNDERRUN_EN.
module line_buff_ctrl
  import vga_pkg::*;
#(
  parameter int WIDTH_PX       = DEF_WIDTH_PX,
  parameter int HEIGHT_PX      = DEF_HEIGHT_PX,
  parameter int TILE_WIDTH     = DEF_TILE_WIDTH,
  parameter int TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
  parameter int TILE_CTR_WIDTH = $clog2(TILE_PER_LINE),
  parameter int LINE_CTR_WIDTH = $clog2(HEIGHT_PX)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      frame_start_i,
  input  logic                      pxl_ce_i,
  input  logic                      disp_active_i,
  input  logic [1:0]                buff_fill_done_i,
  output logic [1:0]                buff_fill_req_o,
  output logic [1:0]                buff_sel_o,
  output logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o,
  output logic [LINE_CTR_WIDTH-1:0] fill_line_o
`ifdef LINE_BUFF_CTRL_UNDERRUN_EN
  ,
  output logic                      underrun_o
`endif
);

  localparam logic [LINE_CTR_WIDTH-1:0] LINE_ONE = LINE_CTR_WIDTH'(1);
  localparam logic [LINE_CTR_WIDTH-1:0] LINE_TWO = LINE_CTR_WIDTH'(2);

  line_ctrl_state_t          state;
  logic [LINE_CTR_WIDTH-1:0] line_ctr;
  logic [1:0]                fill_buf;
  logic                      start_pend;
  logic                      active_prev;
  logic                      line_end;
  logic                      done_hit;
  logic                      more_fill;
  logic                      last_line;
  logic                      restart;

  assign line_end  = pxl_ce_i && !disp_active_i && active_prev;
  assign done_hit  = |(buff_fill_done_i & buff_fill_req_o);
  assign more_fill = (int'(line_ctr) + 2) < HEIGHT_PX;
  assign last_line = (int'(line_ctr) + 1) == HEIGHT_PX;

  // Decide whether priming restarts now; an outstanding request is never abandoned.
  always_comb begin
    restart = 1'b0;
    case (state)
      IDLE, ACTIVE:        restart = frame_start_i;
      PRIME0, PRIME1, FILL: restart = done_hit && (start_pend || frame_start_i);
      default:             restart = 1'b0;
    endcase
  end

  // Remember the last sampled visible flag to find the falling edge that ends a line.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      active_prev <= 1'b0;
    end else if (pxl_ce_i) begin
      active_prev <= disp_active_i;
    end
  end

  // Main controller FSM with registered request, select and fill-line outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state           <= IDLE;
      buff_fill_req_o <= 2'b00;
      buff_sel_o      <= BUFF_A;
      fill_line_o     <= '0;
      line_ctr        <= '0;
      fill_buf        <= BUFF_A;
      start_pend      <= 1'b0;
    end else if (restart) begin
      state           <= PRIME0;
      buff_fill_req_o <= 2'b00;
      buff_sel_o      <= BUFF_A;
      fill_line_o     <= '0;
      line_ctr        <= '0;
      start_pend      <= 1'b0;
    end else begin
      if (frame_start_i) begin
        start_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          buff_fill_req_o <= 2'b00;
        end
        PRIME0: begin
          if (done_hit) begin
            buff_fill_req_o <= 2'b00;
            if (HEIGHT_PX == 1) begin
              state <= ACTIVE;
            end else begin
              state       <= PRIME1;
              fill_line_o <= LINE_ONE;
            end
          end else begin
            buff_fill_req_o <= BUFF_A;
          end
        end
        PRIME1: begin
          if (done_hit) begin
            buff_fill_req_o <= 2'b00;
            state           <= ACTIVE;
          end else begin
            buff_fill_req_o <= BUFF_B;
          end
        end
        ACTIVE: begin
          buff_fill_req_o <= 2'b00;
          if (line_end) begin
            buff_sel_o <= other_buff(buff_sel_o);
            line_ctr   <= line_ctr + LINE_ONE;
            if (more_fill) begin
              fill_line_o <= line_ctr + LINE_TWO;
              fill_buf    <= buff_sel_o;
              state       <= FILL;
            end else if (last_line) begin
              state <= IDLE;
            end
          end
        end
        FILL: begin
          if (line_end) begin
            buff_sel_o <= other_buff(buff_sel_o);
            line_ctr   <= line_ctr + LINE_ONE;
          end
          if (done_hit) begin
            buff_fill_req_o <= 2'b00;
            state           <= ACTIVE;
            if (line_end && more_fill) begin
              fill_line_o <= line_ctr + LINE_TWO;
              fill_buf    <= buff_sel_o;
              state       <= FILL;
            end else if (line_end && last_line) begin
              state <= IDLE;
            end
          end else begin
            buff_fill_req_o <= fill_buf;
          end
        end
        default: begin
          state           <= IDLE;
          buff_fill_req_o <= 2'b00;
        end
      endcase
    end
  end

`ifdef LINE_BUFF_CTRL_UNDERRUN_EN
  // Flag a line starting on a buffer that is still being primed or refilled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      underrun_o <= 1'b0;
    end else if (frame_start_i) begin
      underrun_o <= 1'b0;
    end else if (pxl_ce_i && disp_active_i && !active_prev &&
                 ((state == PRIME0) || (state == PRIME1) ||
                  ((state == FILL) && (fill_buf == buff_sel_o)))) begin
      underrun_o <= 1'b1;
    end
  end
`endif

  tile_ctr #(
    .TILE_WIDTH     (TILE_WIDTH),
    .TILE_PER_LINE  (TILE_PER_LINE),
    .TILE_CTR_WIDTH (TILE_CTR_WIDTH)
  ) u_tile_ctr (
    .clk         (clk_i),
    .rst_n       (rstn_i),
    .pxl_ce      (pxl_ce_i),
    .disp_active (disp_active_i),
    .tile_id     (disp_pxl_id_o)
  );

endmodule

// File: tb/tb_line_buff_ctrl.sv
// Directed bench for line_buff_ctrl on a 16x4 screen with 4-pixel tiles.
// Exercises the underrun flag when LINE_BUFF_CTRL_UNDERRUN_EN is defined.
module tb_line_buff_ctrl;

  logic       clk;
  logic       rstn;
  logic       frame_start;
  logic       pxl_ce;
  logic       disp_active;
  logic [1:0] buff_fill_done;
  logic [1:0] buff_fill_req;
  logic [1:0] buff_sel;
  logic [1:0] disp_pxl_id;
  logic [1:0] fill_line;
`ifdef LINE_BUFF_CTRL_UNDERRUN_EN
  logic       underrun;
`endif

  int checks = 0;
  int errors = 0;

  line_buff_ctrl #(
    .WIDTH_PX   (16),
    .HEIGHT_PX  (4),
    .TILE_WIDTH (4)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .frame_start_i    (frame_start),
    .pxl_ce_i         (pxl_ce),
    .disp_active_i    (disp_active),
    .buff_fill_done_i (buff_fill_done),
    .buff_fill_req_o  (buff_fill_req),
    .buff_sel_o       (buff_sel),
    .disp_pxl_id_o    (disp_pxl_id),
    .fill_line_o      (fill_line)
`ifdef LINE_BUFF_CTRL_UNDERRUN_EN
    ,
    .underrun_o       (underrun)
`endif
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some sequence never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fill request and check which buffer and line it targets.
  task automatic waitRequest(input string tag, input logic [1:0] exp_req, input int exp_line);
    int n;
    n = 0;
    while (buff_fill_req == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_req"}, buff_fill_req, exp_req);
    checkOutput({tag, "_line"}, fill_line, exp_line);
  endtask

  // Answer a request with its done pulse three cycles after it appears.
  task automatic applyStimulus(input string tag, input logic [1:0] exp_req, input int exp_line);
    waitRequest(tag, exp_req, exp_line);
    repeat (2) tick();
    checkOutput({tag, "_hold"}, fill_line, exp_line);
    buff_fill_done = exp_req;
    tick();
    buff_fill_done = 2'b00;
    checkOutput({tag, "_drop"}, buff_fill_req, 0);
  endtask

  // One visible line of 16 pixels, pixel enable every 4th cycle, then the line end.
  task automatic showLine(input string tag, input logic [1:0] exp_sel);
    for (int p = 0; p < 16; p++) begin
      checkOutput({tag, "_pxl"}, disp_pxl_id, p / 4);
      disp_active = 1'b1;
      pxl_ce      = 1'b1;
      tick();
      pxl_ce = 1'b0;
      repeat (3) tick();
    end
    checkOutput({tag, "_sat"}, disp_pxl_id, 3);
    disp_active = 1'b0;
    pxl_ce      = 1'b1;
    tick();
    pxl_ce = 1'b0;
    checkOutput({tag, "_sel"}, buff_sel, exp_sel);
    checkOutput({tag, "_clr"}, disp_pxl_id, 0);
  endtask

  task automatic primeFrame(input string tag);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    applyStimulus({tag, "_p0"}, 2'b01, 0);
    applyStimulus({tag, "_p1"}, 2'b10, 1);
    checkOutput({tag, "_sel"}, buff_sel, 1);
  endtask

  initial begin
    rstn           = 1'b0;
    frame_start    = 1'b0;
    pxl_ce         = 1'b0;
    disp_active    = 1'b0;
    buff_fill_done = 2'b00;
    repeat (3) tick();
    checkOutput("rst_req", buff_fill_req, 0);
    checkOutput("rst_sel", buff_sel, 1);
    checkOutput("rst_pxl", disp_pxl_id, 0);
    checkOutput("rst_line", fill_line, 0);
`ifdef LINE_BUFF_CTRL_UNDERRUN_EN
    checkOutput("rst_underrun", underrun, 0);
`endif
    rstn = 1'b1;
    repeat (2) tick();

    // Full frame: fills only for lines 2 and 3, then idle.
    primeFrame("f");
    showLine("l0", 2'b10);
    applyStimulus("f2", 2'b01, 2);
    showLine("l1", 2'b01);
    applyStimulus("f3", 2'b10, 3);
    showLine("l2", 2'b10);
    repeat (4) tick();
    checkOutput("l2_nofill", buff_fill_req, 0);
    showLine("l3", 2'b01);
    repeat (4) tick();
    checkOutput("l3_nofill", buff_fill_req, 0);
    showLine("idle", 2'b01);
    repeat (4) tick();
    checkOutput("idle_req", buff_fill_req, 0);

    // Asynchronous reset while buffer B is being refilled.
    primeFrame("r");
    showLine("r0", 2'b10);
    applyStimulus("rf2", 2'b01, 2);
    showLine("r1", 2'b01);
    waitRequest("rf3", 2'b10, 3);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_req", buff_fill_req, 0);
    checkOutput("arst_sel", buff_sel, 1);
    checkOutput("arst_line", fill_line, 0);
    checkOutput("arst_pxl", disp_pxl_id, 0);
    #2;
    rstn = 1'b1;
    repeat (5) tick();
    checkOutput("post_rst_req", buff_fill_req, 0);
    checkOutput("post_rst_sel", buff_sel, 1);

    // Frame start during a fill: request held until done, then priming restarts.
    primeFrame("s");
    showLine("s0", 2'b10);
    waitRequest("s_fill", 2'b01, 2);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    checkOutput("s_held_req", buff_fill_req, 1);
    checkOutput("s_held_line", fill_line, 2);
    buff_fill_done = 2'b01;
    tick();
    buff_fill_done = 2'b00;
    checkOutput("s_done_req", buff_fill_req, 0);
    checkOutput("s_restart_sel", buff_sel, 1);
    tick();
    checkOutput("s_prime_req", buff_fill_req, 1);
    checkOutput("s_prime_line", fill_line, 0);
    buff_fill_done = 2'b10;
    tick();
    buff_fill_done = 2'b00;
    repeat (2) tick();
    checkOutput("s_spur_req", buff_fill_req, 1);
    applyStimulus("s_p0", 2'b01, 0);
    applyStimulus("s_p1", 2'b10, 1);

`ifdef LINE_BUFF_CTRL_UNDERRUN_EN
    // Withhold the line-2 fill until after line 2 has started on buffer A.
    checkOutput("u_init", underrun, 0);
    showLine("u0", 2'b10);
    waitRequest("u_fill", 2'b01, 2);
    showLine("u1", 2'b01);
    checkOutput("u_before", underrun, 0);
    showLine("u2", 2'b10);
    checkOutput("u_set", underrun, 1);
    applyStimulus("u_f2", 2'b01, 2);
    repeat (3) tick();
    checkOutput("u_sticky", underrun, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checkOutput("u_clear", underrun, 0);
    applyStimulus("u_p0", 2'b01, 0);
    applyStimulus("u_p1", 2'b10, 1);
    checkOutput("u_after", underrun, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
